// File: rtl/branch_predictor_gshare.sv
// Gshare direction predictor with a tagged BTB, speculative global history and
// two retire ports. One registered lookup per cycle; updates land at the edge.
module branch_predictor_gshare #(
    parameter int PC_W   = 9,
    parameter int IDX_W  = 6,
    parameter int TAG_W  = 3,
    parameter int HIST_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_valid,
    input  logic [PC_W-1:0]   fetch_pc,
    input  logic              spec_update,
    input  logic              spec_dir,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    output logic [HIST_W-1:0] pred_hist,
    input  logic              upd1_valid,
    input  logic [PC_W-1:0]   upd1_pc,
    input  logic              upd1_taken,
    input  logic [PC_W-1:0]   upd1_target,
    input  logic [HIST_W-1:0] upd1_hist,
    input  logic              upd1_mispredict,
    input  logic              upd2_valid,
    input  logic [PC_W-1:0]   upd2_pc,
    input  logic              upd2_taken,
    input  logic [PC_W-1:0]   upd2_target,
    input  logic [HIST_W-1:0] upd2_hist,
    input  logic              upd2_mispredict,
    output logic [CNT_W-1:0]  mispred_count
);
    localparam int NE = 1 << IDX_W;

    logic [1:0]        pht_q     [NE];
    logic [1:0]        pht_d     [NE];
    logic              btb_v_q   [NE];
    logic              btb_v_d   [NE];
    logic [TAG_W-1:0]  btb_tag_q [NE];
    logic [TAG_W-1:0]  btb_tag_d [NE];
    logic [PC_W-1:0]   btb_tgt_q [NE];
    logic [PC_W-1:0]   btb_tgt_d [NE];

    logic [HIST_W-1:0] ghr_q, ghr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pred_valid_q, pred_valid_d;
    logic              pred_taken_q, pred_taken_d;
    logic [PC_W-1:0]   pred_target_q, pred_target_d;
    logic [HIST_W-1:0] pred_hist_q, pred_hist_d;

    logic [IDX_W-1:0]  u1_pidx, u2_pidx, u1_bidx, u2_bidx;
    logic [IDX_W-1:0]  f_pidx, f_bidx;
    logic [TAG_W-1:0]  f_tag;
    logic              u2_en, recover, f_hit, f_taken;

    function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
        if (up)
            return (c == 2'b11) ? c : c + 2'b01;
        else
            return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    assign u1_bidx = upd1_pc[IDX_W-1:0];
    assign u2_bidx = upd2_pc[IDX_W-1:0];
    assign u1_pidx = u1_bidx ^ IDX_W'(upd1_hist);
    assign u2_pidx = u2_bidx ^ IDX_W'(upd2_hist);
    // A mispredicting older branch makes the younger slot wrong-path.
    assign u2_en   = upd2_valid && !(upd1_valid && upd1_mispredict);

    assign f_bidx  = fetch_pc[IDX_W-1:0];
    assign f_pidx  = f_bidx ^ IDX_W'(ghr_q);
    assign f_tag   = fetch_pc[IDX_W+TAG_W-1:IDX_W];
    assign f_hit   = btb_v_q[f_bidx] && (btb_tag_q[f_bidx] == f_tag);
    assign f_taken = f_hit && pht_q[f_pidx][1];

    // Table updates: port 1 first, port 2 layered on its result.
    always_comb begin
        pht_d     = pht_q;
        btb_v_d   = btb_v_q;
        btb_tag_d = btb_tag_q;
        btb_tgt_d = btb_tgt_q;
        if (upd1_valid) begin
            pht_d[u1_pidx] = sat2(pht_d[u1_pidx], upd1_taken);
            if (upd1_taken) begin
                btb_v_d[u1_bidx]   = 1'b1;
                btb_tag_d[u1_bidx] = upd1_pc[IDX_W+TAG_W-1:IDX_W];
                btb_tgt_d[u1_bidx] = upd1_target;
            end
        end
        if (u2_en) begin
            pht_d[u2_pidx] = sat2(pht_d[u2_pidx], upd2_taken);
            if (upd2_taken) begin
                btb_v_d[u2_bidx]   = 1'b1;
                btb_tag_d[u2_bidx] = upd2_pc[IDX_W+TAG_W-1:IDX_W];
                btb_tgt_d[u2_bidx] = upd2_target;
            end
        end
    end

    always_comb begin
        ghr_d   = ghr_q;
        recover = 1'b0;
        if (upd1_valid && upd1_mispredict) begin
            ghr_d   = {upd1_hist[HIST_W-2:0], upd1_taken};
            recover = 1'b1;
        end else if (u2_en && upd2_mispredict) begin
            ghr_d   = {upd2_hist[HIST_W-2:0], upd2_taken};
            recover = 1'b1;
        end else if (spec_update) begin
            ghr_d   = {ghr_q[HIST_W-2:0], spec_dir};
        end
        cnt_d = (recover && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_comb begin
        pred_valid_d  = fetch_valid;
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        pred_hist_d   = pred_hist_q;
        if (fetch_valid) begin
            pred_taken_d  = f_taken;
            pred_target_d = f_taken ? btb_tgt_q[f_bidx] : fetch_pc + PC_W'(1);
            pred_hist_d   = ghr_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NE; i++) begin
                pht_q[i]     <= 2'b01;
                btb_v_q[i]   <= 1'b0;
                btb_tag_q[i] <= '0;
                btb_tgt_q[i] <= '0;
            end
            ghr_q         <= '0;
            cnt_q         <= '0;
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            pred_hist_q   <= '0;
        end else begin
            pht_q         <= pht_d;
            btb_v_q       <= btb_v_d;
            btb_tag_q     <= btb_tag_d;
            btb_tgt_q     <= btb_tgt_d;
            ghr_q         <= ghr_d;
            cnt_q         <= cnt_d;
            pred_valid_q  <= pred_valid_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
            pred_hist_q   <= pred_hist_d;
        end
    end

    assign pred_valid    = pred_valid_q;
    assign pred_taken    = pred_taken_q;
    assign pred_target   = pred_target_q;
    assign pred_hist     = pred_hist_q;
    assign mispred_count = cnt_q;
endmodule
